tetris_field_engine: RTL

//  Owns the Tetris playfield bitmap and replaces the hard-wired 400-bit field path with a parametrised engine.

---
 rtl/tetris_field_engine_pkg.sv | 17 +
 rtl/tetris_field_engine_if.sv | 11 +
 rtl/tetris_row_select.sv | 25 ++
 rtl/tetris_field_engine.sv | 134 +++++++++++++
 4 files changed

// File: rtl/tetris_field_engine_pkg.sv
// Shared definitions for the Tetris playfield engine: FSM encodings, defaults and cell indexing.
package tetris_field_engine_pkg;

  localparam int unsigned DEF_COLS = 20;
  localparam int unsigned DEF_ROWS = 20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Flat bit index of cell (row r, col c); row 0 is the top of the field.
  function automatic int unsigned cell_idx(int unsigned r, int unsigned c, int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/tetris_field_engine_if.sv
// Piece-lock handshake between the game controller (master) and the field engine (slave).
interface tetris_field_engine_if #(
  parameter int unsigned N = 400
) ();
  logic         lock_valid;
  logic         lock_ready;
  logic [N-1:0] lock_mask;

  modport master (output lock_valid, output lock_mask, input lock_ready);
  modport slave  (input lock_valid, input lock_mask, output lock_ready);
endinterface

// File: rtl/tetris_row_select.sv
// Selects one row of the playfield and reports whether every cell in it is occupied.
module tetris_row_select
  import tetris_field_engine_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned RW   = 5,
  localparam int unsigned N   = COLS * ROWS
) (
  input  logic [N-1:0]  field,
  input  logic [RW-1:0] row,
  output logic          full
);

  logic [COLS-1:0] rows [ROWS];
  logic [COLS-1:0] row_bits;

  for (genvar i = 0; i < ROWS; i++) begin : g_rows
    assign rows[i] = field[cell_idx(i, 0, COLS) +: COLS];
  end

  assign row_bits = rows[row];
  assign full     = &row_bits;

endmodule

// File: rtl/tetris_field_engine.sv
// Playfield owner: merges locked pieces, clears full rows with gravity, tracks lines and game over.
module tetris_field_engine
  import tetris_field_engine_pkg::*;
#(
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned SPAWN_ROWS = 2,
  parameter int unsigned SCORE_W    = 16,
  localparam int unsigned N         = COLS * ROWS,
  localparam int unsigned CW        = $clog2(ROWS + 1)
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 clear_all,
  tetris_field_engine_if.slave lock,
  output logic [N-1:0]         field,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        lines_cleared,
  output logic [SCORE_W-1:0]   lines_total,
  output logic                 game_over
);

  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SUM_W = ((SCORE_W > CW) ? SCORE_W : CW) + 1;
  localparam logic [SUM_W-1:0] SCORE_MAX = {{(SUM_W - SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  logic [1:0]         state, state_d;
  logic [RW-1:0]      row_ptr, row_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [N-1:0]       field_d, shifted;
  logic [CW-1:0]      lc_d;
  logic [SCORE_W-1:0] lt_d;
  logic               go_d;
  logic               row_full;
  logic [SUM_W-1:0]   sum;

  tetris_row_select #(.COLS(COLS), .ROWS(ROWS), .RW(RW)) u_row_select (
    .field (field),
    .row   (row_ptr),
    .full  (row_full)
  );

  // Gravity: rows 1..row_ptr take the row above them, row 0 empties.
  for (genvar i = 0; i < ROWS; i++) begin : g_shift
    logic en;
    assign en = (RW'(i) <= row_ptr);
    if (i == 0) begin : g_top
      assign shifted[COLS-1:0] = en ? '0 : field[COLS-1:0];
    end else begin : g_body
      assign shifted[i*COLS +: COLS] = en ? field[(i-1)*COLS +: COLS] : field[i*COLS +: COLS];
    end
  end

  // Wide enough that the total cannot wrap before it is clamped.
  assign sum = SUM_W'(lines_total) + SUM_W'(cnt);

  // Next-state and datapath decode.
  always_comb begin
    state_d = state;
    field_d = field;
    row_d   = row_ptr;
    cnt_d   = cnt;
    lc_d    = lines_cleared;
    lt_d    = lines_total;
    go_d    = game_over;
    case (state)
      ST_IDLE: begin
        if (lock.lock_valid && !game_over) begin
          field_d = field | lock.lock_mask;
          row_d   = RW'(ROWS - 1);
          cnt_d   = '0;
          state_d = ST_SCAN;
          if (|(field & lock.lock_mask)) go_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (row_full) begin
          cnt_d   = cnt + CW'(1);
          state_d = ST_SHIFT;
        end else if (row_ptr == '0) begin
          state_d = ST_DONE;
        end else begin
          row_d = row_ptr - RW'(1);
        end
      end
      ST_SHIFT: begin
        field_d = shifted;
        state_d = ST_SCAN;
      end
      ST_DONE: begin
        lc_d    = cnt;
        lt_d    = (sum > SCORE_MAX) ? '1 : SCORE_W'(sum);
        state_d = ST_IDLE;
        if (|field[SPAWN_ROWS*COLS-1:0]) go_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear_all) begin
      field_d = '0;
      lc_d    = '0;
      lt_d    = '0;
      go_d    = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      row_ptr         <= '0;
      cnt             <= '0;
      field           <= '0;
      lines_cleared   <= '0;
      lines_total     <= '0;
      game_over       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      lock.lock_ready <= 1'b1;
    end else begin
      state           <= state_d;
      row_ptr         <= row_d;
      cnt             <= cnt_d;
      field           <= field_d;
      lines_cleared   <= lc_d;
      lines_total     <= lt_d;
      game_over       <= go_d;
      busy            <= (state_d != ST_IDLE);
      done            <= (state_d == ST_DONE);
      lock.lock_ready <= (state_d == ST_IDLE) && !go_d;
    end
  end

endmodule
